// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-high, bit 0 = segment a .. bit 6 = segment g.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Hex digit -> gfedcba pattern; entry [0] is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sevenseg_scan_decode.sv
// Combinational hex-to-seven-segment decoder, active-high gfedcba output.
module hex7seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = HEX_SEG_TABLE[hex];
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles: BLANK_CYCLES with all anodes off,
// then the digit is shown. The four input digits are latched once per frame
// (at the start of digit 0's slot) so a mid-scan update never tears a frame.
// Optional macro SEVENSEG_LZB_EN enables leading-zero blanking of digits 3..1.
// All outputs are registered and reflect the state held before each edge.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [1:0]                       idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       frame_q, frame_d;
    logic [3:0]                       an_q, an_d;
    logic [6:0]                       seg_q, seg_d;
    logic                             dp_q, dp_d;

    logic                             frame_start;
    logic [NUM_DIGITS-1:0]            lead_blank;
    logic [3:0]                       hex_sel;
    logic [6:0]                       dec_seg;

    // State, counter, frame and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    // Next state: slot counter wraps every slot; BLANK gap then SHOW, advancing digit at slot end.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BLANK;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase
    end

    // Frame latch: capture all four digits only at the very start of digit 0's slot.
    always_comb begin
        frame_start = (state_q == BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
        frame_d     = frame_q;
        if (frame_start) begin
            frame_d = {digit3, digit2, digit1, digit0};
        end
    end

    // Leading-zero flags derived from the latched frame; digit 0 is never blanked.
    always_comb begin
        lead_blank = '0;
`ifdef SEVENSEG_LZB_EN
        lead_blank[3] = (frame_q[3] == 4'd0);
        lead_blank[2] = lead_blank[3] && (frame_q[2] == 4'd0);
        lead_blank[1] = lead_blank[2] && (frame_q[1] == 4'd0);
`endif
    end

    // Select the digit for the current slot and decode it.
    always_comb begin
        hex_sel = frame_q[idx_q];
    end

    hex7seg_decode u_decode (
        .hex (hex_sel),
        .seg (dec_seg)
    );

    // Output decode: one active-low anode and inverted pattern in SHOW, everything off otherwise.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if ((state_q == SHOW) && !lead_blank[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~dec_seg;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
